// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the divider arbiter and its round-robin picker.
package div_arbiter_pkg;

    localparam int unsigned DEF_N       = 22;
    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    // Width needed to hold an index or count below n (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_IDX_W = idx_width(DEF_NUM_REQ);

endpackage

// File: rtl/div_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after ptr.
module rr_picker
    import div_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    // Scan NUM_REQ positions starting at ptr, wrapping; the first set bit wins.
    always_comb begin
        int unsigned pos;
        pos    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = (32'(ptr) + i) % NUM_REQ;
            if (!valid && req[IDX_W'(pos)]) begin
                winner = IDX_W'(pos);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter serialising divide requests onto one shared divider,
// with a watchdog that aborts a transaction if the divider never finishes.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int unsigned N       = DEF_N,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0][N-1:0] dividend,
    input  logic [NUM_REQ-1:0][N-1:0] divisor,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic signed [N-1:0]       result_q,
    output logic                      dbz,
    output logic                      overflow,
    output logic                      timeout,
    output logic                      div_start,
    output logic signed [N-1:0]       div_dividend,
    output logic signed [N-1:0]       div_divisor,
    input  logic                      div_busy,
    input  logic                      div_done,
    input  logic                      div_dbz,
    input  logic                      div_overflow,
    input  logic signed [N-1:0]       div_output_q
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned WD_W  = idx_width(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [WD_W-1:0]  wd;
    logic             wd_expired;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; div_done is only honoured while waiting on the divider.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_valid) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (div_done || wd_expired) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs, decoded purely from the registered state and winner.
    always_comb begin
        gnt       = '0;
        done      = '0;
        div_start = (state == START);
        if (state != IDLE) gnt[winner] = 1'b1;
        if (state == RESP) done[winner] = 1'b1;
    end

    // Transaction datapath: winner/operand latch, watchdog, result capture, pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner       <= '0;
            ptr          <= '0;
            wd           <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            result_q     <= '0;
            dbz          <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner       <= pick_idx;
                        div_dividend <= dividend[pick_idx];
                        div_divisor  <= divisor[pick_idx];
                    end
                end
                START: wd <= '0;
                WAIT: begin
                    if (div_done) begin
                        result_q <= div_output_q;
                        dbz      <= div_dbz;
                        overflow <= div_overflow;
                        timeout  <= 1'b0;
                    end else if (wd_expired) begin
                        result_q <= '0;
                        dbz      <= 1'b0;
                        overflow <= 1'b0;
                        timeout  <= 1'b1;
                    end else if (wd != '1) begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                default: ;
            endcase
        end
    end

    // The divider must report busy for as long as a transaction waits on it.
    assert property (@(posedge clk) disable iff (rst) (state == WAIT) |-> div_busy);

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider, randomized requesters,
// and a scoreboard checked by an independent monitor.
module tb_div_arbiter;

    localparam int N       = 22;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0][N-1:0] dividend;
    logic [NUM_REQ-1:0][N-1:0] divisor;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic signed [N-1:0]       result_q;
    logic                      dbz;
    logic                      overflow;
    logic                      timeout;
    logic                      div_start;
    logic signed [N-1:0]       div_dividend;
    logic signed [N-1:0]       div_divisor;
    logic                      div_busy;
    logic                      div_done;
    logic                      div_dbz;
    logic                      div_overflow;
    logic signed [N-1:0]       div_output_q;

    div_arbiter #(
        .N       (N),
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .dividend     (dividend),
        .divisor      (divisor),
        .gnt          (gnt),
        .done         (done),
        .result_q     (result_q),
        .dbz          (dbz),
        .overflow     (overflow),
        .timeout      (timeout),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .div_dbz      (div_dbz),
        .div_overflow (div_overflow),
        .div_output_q (div_output_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         r;
        logic [N-1:0] q;
        logic       dbz;
        logic       ovf;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   cycle  = 0;
    logic [NUM_REQ-1:0] last_req = '0;
    bit   hang      = 1'b0;
    int   fixed_lat = 0;
    int   mdl_lat   = 0;
    int   mdl_cnt   = 0;
    exp_t pend;

    // Q10 quotient of a/b from plain integer arithmetic; divide-by-zero returns all ones.
    function automatic exp_t ref_div(input int r, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t   e;
        longint sa, sbv, full, lim;
        e.r  = r;
        e.to = 1'b0;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        lim  = longint'(1) <<< (N - 1);
        if (sbv == 0) begin
            e.q   = '1;
            e.dbz = 1'b1;
            e.ovf = 1'b0;
        end else begin
            full  = (sa * 1024) / sbv;
            e.q   = N'(full);
            e.dbz = 1'b0;
            e.ovf = (full >= lim) || (full < -lim);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s: bound expired or no matching expectation", name);
    endtask

    // Behavioural divider: latency D cycles after start, or never finishes when hung.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_busy     <= 1'b0;
            div_done     <= 1'b0;
            div_dbz      <= 1'b0;
            div_overflow <= 1'b0;
            div_output_q <= '0;
            mdl_cnt      <= 0;
        end else begin
            div_done <= 1'b0;
            if (div_start) begin
                div_busy <= 1'b1;
                mdl_cnt  <= 1;
                mdl_lat  <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(2, 16));
                pend     <= ref_div(0, div_dividend, div_divisor);
            end else if (div_busy) begin
                if (div_done) begin
                    div_busy <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt + 1;
                    if (!hang && mdl_cnt == mdl_lat - 1) begin
                        div_done     <= 1'b1;
                        div_output_q <= pend.q;
                        div_dbz      <= pend.dbz;
                        div_overflow <= pend.ovf;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        cycle    <= cycle + 1;
        last_req <= req;
    end

    // Monitor: predicts each grant by round-robin search and scores each done pulse.
    logic [NUM_REQ-1:0] m_prev_gnt = '0;
    int m_ptr    = 0;
    int m_gcyc   = 0;
    int m_starts = 0;
    int m_w      = 0;
    int m_idx    = 0;
    int m_found  = 0;
    exp_t m_e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_prev_gnt = '0;
                m_ptr      = 0;
                m_starts   = 0;
            end else begin
                if (gnt != '0 && m_prev_gnt == '0) begin
                    m_w = -1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        int j;
                        j = (m_ptr + k) % NUM_REQ;
                        if (m_w < 0 && last_req[j]) m_w = j;
                    end
                    if (m_w < 0) fail("grant_without_request");
                    else chk("grant", 64'(gnt), 64'(1) << m_w);
                    m_gcyc   = cycle;
                    m_starts = 0;
                end
                if (div_start) m_starts++;
                if (done != '0) begin
                    chk("done_matches_gnt", 64'(done), 64'(gnt));
                    m_idx = -1;
                    for (int k = NUM_REQ - 1; k >= 0; k--) if (done[k]) m_idx = k;
                    m_found = -1;
                    foreach (sb[i]) if (m_found < 0 && sb[i].r == m_idx) m_found = i;
                    if (m_found < 0) begin
                        fail("unexpected_done");
                    end else begin
                        m_e = sb[m_found];
                        sb.delete(m_found);
                        chk("result_q", 64'($unsigned(result_q)), 64'(m_e.q));
                        chk("dbz", 64'(dbz), 64'(m_e.dbz));
                        chk("overflow", 64'(overflow), 64'(m_e.ovf));
                        chk("timeout", 64'(timeout), 64'(m_e.to));
                        chk("latency", 64'(cycle - m_gcyc), 64'(m_e.to ? TIMEOUT + 1 : mdl_lat + 1));
                        chk("one_start", 64'(m_starts), 64'd1);
                    end
                    m_ptr = (m_idx + 1) % NUM_REQ;
                end
                m_prev_gnt = gnt;
            end
        end
    end

    task automatic issue(input int r, input logic [N-1:0] a, input logic [N-1:0] b, input bit to_exp);
        exp_t e;
        e = ref_div(r, a, b);
        if (to_exp) begin
            e.q   = '0;
            e.dbz = 1'b0;
            e.ovf = 1'b0;
            e.to  = 1'b1;
        end
        dividend[r] = a;
        divisor[r]  = b;
        req[r]      = 1'b1;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int r);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done[r]) begin
                req[r] = 1'b0;
                return;
            end
        end
        fail("done_wait");
        req[r] = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic requester(input int r, input int n);
        logic [N-1:0] a, b;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = N'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = N'($urandom_range(1, 3));
                default: b = N'($urandom);
            endcase
            issue(r, a, b, 1'b0);
            wait_done(r);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_div_start"}, 64'(div_start), 64'd0);
        chk({tag, "_result_q"}, 64'($unsigned(result_q)), 64'd0);
        chk({tag, "_flags"}, 64'({dbz, overflow, timeout}), 64'd0);
        chk({tag, "_operands"}, 64'({$unsigned(div_dividend), $unsigned(div_divisor)}), 64'd0);
    endtask

    initial begin
        req      = '0;
        dividend = '0;
        divisor  = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 3.0 / 1.5 with a 12-cycle divider
        fixed_lat = 12;
        issue(1, 22'd3072, 22'd1536, 1'b0);
        wait_done(1);

        // divide by zero
        issue(0, 22'd1024, 22'd0, 1'b0);
        wait_done(0);
        fixed_lat = 0;

        // all four requesting after reset: order 0,1,2,3,0
        reset_dut();
        fork
            begin
                issue(0, 22'd2048, 22'd1024, 1'b0);
                wait_done(0);
                issue(0, 22'd1000, 22'd3000, 1'b0);
                wait_done(0);
            end
            begin issue(1, 22'd5000, 22'd700, 1'b0);  wait_done(1); end
            begin issue(2, -22'sd4096, 22'd512, 1'b0); wait_done(2); end
            begin issue(3, 22'd900000, 22'd1, 1'b0);  wait_done(3); end
        join

        // pointer wrap: serve 2 alone, then 0 and 3 together -> 3 first
        issue(2, 22'd777, 22'd333, 1'b0);
        wait_done(2);
        fork
            begin issue(3, 22'd6144, 22'd2048, 1'b0); wait_done(3); end
            begin issue(0, 22'd1536, 22'd3072, 1'b0); wait_done(0); end
        join

        // divider never answers: watchdog abort, then normal service resumes
        hang = 1'b1;
        issue(2, 22'd4096, 22'd1024, 1'b1);
        wait_done(2);
        hang = 1'b0;
        issue(1, 22'd3072, 22'd1024, 1'b0);
        wait_done(1);

        // reset five cycles into a transaction, requester 3 keeps requesting
        fixed_lat = 30;
        issue(3, 22'd5120, 22'd2048, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (div_start) break;
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("reset_mid_wait");
        sb.delete();
        fixed_lat = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.push_back(ref_div(3, 22'd5120, 22'd2048));
        wait_done(3);

        // randomized contention
        fork
            requester(0, 8);
            requester(1, 8);
            requester(2, 8);
            requester(3, 8);
        join

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter that shares the single multi-cycle fixed-point divider among several requesters in the accelerator datapath. It accepts independent divide requests, serialises them onto the divider's start/busy/done handshake and routes the quotient and status flags back to the winning requester. A watchdog bounds each transaction so a stalled divider cannot hang the requesters.

## Interface
- N, 22, fixed-point word width (Q10 format, passed through untouched)
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 64, max cycles to wait for divider done before aborting
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- req  in  NUM_REQ  per-requester request, level
- dividend  in  NUM_REQ×N signed  per-requester dividend
- divisor  in  NUM_REQ×N signed  per-requester divisor
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
- done  out  NUM_REQ  one-hot, one-cycle completion pulse
- result_q  out  N signed  quotient, valid only in the done cycle
- dbz  out  1  divide-by-zero flag, valid with done
- overflow  out  1  overflow flag, valid with done
- timeout  out  1  watchdog abort flag, valid with done
- div_start  out  1  one-cycle start pulse to divider
- div_dividend, div_divisor  out  N signed  operands to divider, stable from start until done
- div_busy, div_done, div_dbz, div_overflow  in  1  divider status
- div_output_q  in  N signed  divider quotient

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if any req bit set, pick winner = first set bit at index ≥ ptr, wrapping past NUM_REQ-1 to 0; latch winner index and its operands; set gnt; go START. No request → stay.
- START: div_start=1 for exactly this cycle with latched operands; clear watchdog; go WAIT.
- WAIT: watchdog increments each cycle. div_done=1 → latch div_output_q, div_dbz, div_overflow; timeout=0; go RESP. Watchdog reaches TIMEOUT-1 without div_done → latch result 0, dbz 0, overflow 0, timeout 1; go RESP.
- RESP: done[winner]=1, result/flags driven; ptr ← (winner+1) mod NUM_REQ; gnt cleared on exit; go IDLE.
- Requester rule: hold req and operands stable until its done pulse. req sampled again in the following IDLE; still high ⇒ new transaction.
- req deasserted while granted: transaction still completes and done still pulses (no cancellation).
- Operands not latched from the bus after IDLE; later changes on dividend/divisor ignored.
- div_done outside WAIT ignored. div_busy monitored only for assertion in verification (must be 1 in WAIT).
- Reset (any state): FSM→IDLE, ptr=0, watchdog=0; gnt, done, result_q, dbz, overflow, timeout, div_start, div_dividend, div_divisor all 0. The divider shares the same reset net (inverted at integration) so in-flight divisions are discarded.

## Timing
- req sampled high in IDLE at cycle t ⇒ gnt from t+1, div_start at t+1, divider done at t+1+D, done pulse at t+2+D, IDLE again at t+3+D.
- Back-to-back: with req held by another requester, next div_start at t+4+D; minimum 3 cycles of overhead per transaction.
- Timeout: done at t+2+TIMEOUT with timeout=1.
- Fairness: with all requesters continuously requesting, each is served once in every NUM_REQ transactions.
- Outputs registered; no combinational path from req or div_* inputs to any output.

## Structure
- Package div_arbiter_pkg: state enum (IDLE, START, WAIT, RESP), default NUM_REQ, TIMEOUT, and the index width $clog2(NUM_REQ).
- Sub-module rr_picker: combinational round-robin priority encoder (req, ptr → winner index, valid); reused by future arbiters for the sqrt and exp units.
- Watchdog counter sized $clog2(TIMEOUT) bits, saturating.

## Test plan
- Single request: req[1] with 3072 / 1536 (3.0/1.5), divider model D=12 → gnt=0b0010 at t+1, done[1] at t+14, result_q=2048, dbz=0, overflow=0.
- Divide by zero: req[0] with 1024 / 0 → done[0] with dbz=1, result_q as returned by divider, timeout=0.
- Contention: req=0b1111 held after reset → service order 0,1,2,3,0; each done one-hot; no start while WAIT.
- Pointer wrap: ptr=3 after serving 2, req=0b1001 → requester 3 served, then 0.
- Timeout: divider model never asserts done, req[2] → done[2] at t+66 with timeout=1, result_q=0; next request served normally.
- Reset mid-WAIT: assert rst 5 cycles after div_start → all outputs 0 immediately, ptr=0; after release, pending req[3] re-served from START.
